// File: rtl/adc_pkg.sv
// Shared definitions for the SAR ADC datapath: controller state encoding and
// the converter resolution shared with the row/column DAC decoder.
package adc_pkg;

  localparam int ADC_DATA_WIDTH = 12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SAMPLE    = 3'd1,
    TRIAL     = 3'd2,
    WAIT_COMP = 3'd3,
    DONE      = 3'd4
  } adc_state_t;

endpackage

// File: rtl/adc_sar_controller.sv
// Successive-approximation controller: samples, walks one comparator decision
// per bit from MSB to LSB, and publishes the finished code as result_out.
module adc_sar_controller
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH    = ADC_DATA_WIDTH,
  parameter int SAMPLE_CYCLES = 4,
  parameter int COMP_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  comp_valid,
  input  logic                  comp_result,
  output logic                  sample_out,
  output logic                  comp_trigger_out,
  output logic [DATA_WIDTH-1:0] dac_data_out,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  busy_out,
  output logic                  conv_done_out,
  output logic                  timeout_err_out
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [7:0]       SAMPLE_LAST  = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0]       TIMEOUT_LAST = 8'(COMP_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] MSB_IDX      = IDX_W'(DATA_WIDTH - 1);

  adc_state_t            state;
  logic [7:0]            sample_cnt;
  logic [7:0]            wait_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] work;
  logic [DATA_WIDTH-1:0] decided;
  logic [DATA_WIDTH-1:0] next_trial;
  logic                  timeout_hit;
  logic                  resolve;

  // The working register is the trial code itself, so the DAC sees it directly.
  assign dac_data_out = work;

  // A valid decision in the expiry cycle takes priority over the timeout.
  assign timeout_hit = !comp_valid && (wait_cnt == TIMEOUT_LAST);
  assign resolve     = comp_valid || timeout_hit;

  always_comb begin
    decided          = work;
    decided[bit_idx] = comp_valid ? comp_result : 1'b0;
    next_trial       = decided;
    if (bit_idx != '0) begin
      next_trial[bit_idx - IDX_W'(1)] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      sample_cnt       <= '0;
      wait_cnt         <= '0;
      bit_idx          <= '0;
      work             <= '0;
      sample_out       <= 1'b0;
      comp_trigger_out <= 1'b0;
      result_out       <= '0;
      busy_out         <= 1'b0;
      conv_done_out    <= 1'b0;
      timeout_err_out  <= 1'b0;
    end else begin
      comp_trigger_out <= 1'b0;
      conv_done_out    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= SAMPLE;
            sample_cnt      <= '0;
            work            <= '0;
            sample_out      <= 1'b1;
            busy_out        <= 1'b1;
            timeout_err_out <= 1'b0;
          end
        end
        SAMPLE: begin
          if (sample_cnt == SAMPLE_LAST) begin
            state                <= TRIAL;
            sample_out           <= 1'b0;
            bit_idx              <= MSB_IDX;
            work[DATA_WIDTH-1]   <= 1'b1;
            comp_trigger_out     <= 1'b1;
          end else begin
            sample_cnt <= sample_cnt + 8'd1;
          end
        end
        TRIAL: begin
          state    <= WAIT_COMP;
          wait_cnt <= '0;
        end
        WAIT_COMP: begin
          if (resolve) begin
            if (timeout_hit) begin
              timeout_err_out <= 1'b1;
            end
            // result_out is loaded on entry to DONE so it is valid alongside the pulse.
            if (bit_idx == '0) begin
              state         <= DONE;
              work          <= decided;
              result_out    <= decided;
              conv_done_out <= 1'b1;
            end else begin
              state            <= TRIAL;
              bit_idx          <= bit_idx - IDX_W'(1);
              work             <= next_trial;
              comp_trigger_out <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          work     <= '0;
          busy_out <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          work     <= '0;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sar_controller.sv
// Directed bench for adc_sar_controller with an ideal comparator model that
// answers each trigger on the following cycle.
module tb_adc_sar_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        comp_valid;
  logic        comp_result;
  logic        sample_out;
  logic        comp_trigger_out;
  logic [11:0] dac_data_out;
  logic [11:0] result_out;
  logic        busy_out;
  logic        conv_done_out;
  logic        timeout_err_out;

  int tests_run = 0;
  int fails = 0;

  logic [11:0] trials [12];
  int          trial_cnt;
  int          done_cnt;
  int          done_edge;
  int          sample_cnt;
  logic [11:0] res_at_done;
  logic        err_at_done;
  logic        first_err;
  logic        first_busy;
  logic [11:0] idle_dac;
  logic        idle_busy;
  logic        rst_hit;
  logic [11:0] pre_rst_dac;
  logic [28:0] rst_snap;

  adc_sar_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .comp_valid       (comp_valid),
    .comp_result      (comp_result),
    .sample_out       (sample_out),
    .comp_trigger_out (comp_trigger_out),
    .dac_data_out     (dac_data_out),
    .result_out       (result_out),
    .busy_out         (busy_out),
    .conv_done_out    (conv_done_out),
    .timeout_err_out  (timeout_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one conversion against an ideal comparator; outputs are observed 1ns after each edge.
  task automatic do_conv(input logic [11:0] vin, input int hold_bit, input int poke_bit,
                         input int rst_bit, input bit spurious, input bit poke_done);
    int          edge_n;
    bit          pend;
    logic [11:0] pcode;
    int          pbit;
    trial_cnt = 0; done_cnt = 0; done_edge = -1; sample_cnt = 0;
    res_at_done = 'x; err_at_done = 'x; idle_dac = 'x; idle_busy = 'x;
    rst_hit = 1'b0; pend = 1'b0; pcode = '0; pbit = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edge_n = 0;
    first_err = timeout_err_out;
    first_busy = busy_out;
    while (1) begin
      comp_valid = 1'b0;
      comp_result = 1'b0;
      start = 1'b0;
      if (pend) begin
        pend = 1'b0;
        if (pbit != hold_bit) begin
          comp_valid = 1'b1;
          comp_result = (vin >= pcode);
        end
        if (pbit == poke_bit) start = 1'b1;
      end else if (spurious && sample_out) begin
        comp_valid = 1'b1;
        comp_result = 1'b1;
      end
      if (sample_out) sample_cnt++;
      if (comp_trigger_out) begin
        pbit = 11 - trial_cnt;
        if (trial_cnt < 12) trials[trial_cnt] = dac_data_out;
        trial_cnt++;
        pcode = dac_data_out;
        pend = 1'b1;
        if (pbit == rst_bit) begin
          pre_rst_dac = dac_data_out;
          rst_n = 1'b0;
          #1;
          rst_snap = {sample_out, comp_trigger_out, busy_out, conv_done_out,
                      timeout_err_out, dac_data_out, result_out};
          rst_hit = 1'b1;
          comp_valid = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
      if (conv_done_out) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = edge_n;
          res_at_done = result_out;
          err_at_done = timeout_err_out;
          if (poke_done) start = 1'b1;
        end
      end
      if (done_edge >= 0 && edge_n == done_edge + 1) begin
        idle_dac = dac_data_out;
        idle_busy = busy_out;
      end
      if (done_edge >= 0 && edge_n >= done_edge + 4) break;
      if (edge_n >= 300) break;
      @(posedge clk);
      #1;
      edge_n++;
    end
    comp_valid = 1'b0;
    comp_result = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({sample_out, comp_trigger_out, busy_out, conv_done_out, timeout_err_out} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags got %b want 00000",
               {sample_out, comp_trigger_out, busy_out, conv_done_out, timeout_err_out});
    end
    tests_run++;
    if (dac_data_out !== 12'h000 || result_out !== 12'h000) begin
      fails++;
      $display("[TB] FAIL reset_data dac=%h result=%h want 000/000", dac_data_out, result_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ideal();
    do_conv(12'hA5C, -1, -1, -1, 1'b0, 1'b0);
    tests_run++;
    if (trials[0] !== 12'h800 || trials[1] !== 12'hC00 || trials[2] !== 12'hA00 || trials[3] !== 12'hB00) begin
      fails++;
      $display("[TB] FAIL ideal_trials got %h %h %h %h want 800 c00 a00 b00",
               trials[0], trials[1], trials[2], trials[3]);
    end
    tests_run++;
    if (res_at_done !== 12'hA5C) begin
      fails++;
      $display("[TB] FAIL ideal_result got %h want a5c", res_at_done);
    end
    tests_run++;
    if (done_edge != 28 || done_cnt != 1) begin
      fails++;
      $display("[TB] FAIL ideal_latency edge=%0d count=%0d want 28/1", done_edge, done_cnt);
    end
    tests_run++;
    if (sample_cnt != 4 || trial_cnt != 12 || first_busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ideal_shape samples=%0d trials=%0d busy=%b want 4/12/1",
               sample_cnt, trial_cnt, first_busy);
    end
    tests_run++;
    if (idle_dac !== 12'h000 || idle_busy !== 1'b0 || result_out !== 12'hA5C) begin
      fails++;
      $display("[TB] FAIL ideal_idle dac=%h busy=%b result=%h want 000/0/a5c",
               idle_dac, idle_busy, result_out);
    end
  endtask

  task automatic test_extremes();
    do_conv(12'hFFF, -1, -1, -1, 1'b0, 1'b0);
    tests_run++;
    if (res_at_done !== 12'hFFF || err_at_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL all_ones result=%h err=%b want fff/0", res_at_done, err_at_done);
    end
    do_conv(12'h000, -1, -1, -1, 1'b0, 1'b0);
    tests_run++;
    if (res_at_done !== 12'h000 || trials[1] !== 12'h400 || trials[11] !== 12'h001) begin
      fails++;
      $display("[TB] FAIL all_zeros result=%h t1=%h t11=%h want 000/400/001",
               res_at_done, trials[1], trials[11]);
    end
    tests_run++;
    if (idle_dac !== 12'h000) begin
      fails++;
      $display("[TB] FAIL all_zeros_idle_dac got %h want 000", idle_dac);
    end
  endtask

  task automatic test_timeout();
    do_conv(12'hFFF, 5, -1, -1, 1'b0, 1'b0);
    tests_run++;
    if (res_at_done !== 12'hFDF) begin
      fails++;
      $display("[TB] FAIL timeout_result got %h want fdf", res_at_done);
    end
    tests_run++;
    if (err_at_done !== 1'b1 || timeout_err_out !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout_flag done=%b now=%b want 1/1", err_at_done, timeout_err_out);
    end
    tests_run++;
    if (done_edge != 42 || done_cnt != 1) begin
      fails++;
      $display("[TB] FAIL timeout_latency edge=%0d count=%0d want 42/1", done_edge, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_conv(12'h5A3, -1, 7, -1, 1'b0, 1'b1);
    tests_run++;
    if (first_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_clears_err got %b want 0", first_err);
    end
    tests_run++;
    if (res_at_done !== 12'h5A3 || done_cnt != 1 || done_edge != 28) begin
      fails++;
      $display("[TB] FAIL b2b_result result=%h count=%0d edge=%0d want 5a3/1/28",
               res_at_done, done_cnt, done_edge);
    end
    tests_run++;
    if (idle_busy !== 1'b0 || busy_out !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_done_start busy_idle=%b busy_now=%b want 0/0", idle_busy, busy_out);
    end
  endtask

  task automatic test_reset_mid();
    do_conv(12'h777, -1, -1, 3, 1'b0, 1'b0);
    tests_run++;
    if (rst_hit !== 1'b1 || pre_rst_dac[3] !== 1'b1 || rst_snap !== 29'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid hit=%b pre_dac=%h outputs=%h want 1/bit3 set/0",
               rst_hit, pre_rst_dac, rst_snap);
    end
    do_conv(12'h123, -1, -1, -1, 1'b0, 1'b0);
    tests_run++;
    if (res_at_done !== 12'h123 || done_edge != 28) begin
      fails++;
      $display("[TB] FAIL after_reset result=%h edge=%0d want 123/28", res_at_done, done_edge);
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    comp_valid = 1'b1;
    comp_result = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (dac_data_out !== 12'h000 || result_out !== 12'h123 || busy_out !== 1'b0) begin
      fails++;
      $display("[TB] FAIL spurious_idle dac=%h result=%h busy=%b want 000/123/0",
               dac_data_out, result_out, busy_out);
    end
    comp_valid = 1'b0;
    comp_result = 1'b0;
    do_conv(12'h3C6, -1, -1, -1, 1'b1, 1'b0);
    tests_run++;
    if (res_at_done !== 12'h3C6 || trials[0] !== 12'h800 || done_edge != 28) begin
      fails++;
      $display("[TB] FAIL spurious_sample result=%h t0=%h edge=%0d want 3c6/800/28",
               res_at_done, trials[0], done_edge);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    comp_valid = 1'b0;
    comp_result = 1'b0;
    test_reset();
    test_ideal();
    test_extremes();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/adc_sar_controller.md
Name: adc_sar_controller

Overview:
- Successive-approximation control FSM for the SAR ADC.
- Produces the 12-bit trial code that drives adc_row_col_decoder's data_in, runs one comparator decision per bit and latches the final conversion result.
- Sits between the top-level conversion trigger, the comparator, and the row/column DAC decoder. It is the writer side of the decoder's data_in interface.

Parameters:
- DATA_WIDTH, 12, resolution; must equal the decoder data_in width.
- SAMPLE_CYCLES, 4, clock cycles sample_out is held high (range 1..255).
- COMP_TIMEOUT, 15, cycles to wait for comp_valid before forcing a 0 decision (range 1..255).

Ports:
- clk  in  1  conversion clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle conversion request.
- comp_valid  in  1  comparator decision strobe.
- comp_result  in  1  1 = input >= DAC level (keep bit); 0 = clear bit.
- sample_out  out  1  sampling switch enable.
- comp_trigger_out  out  1  single-cycle comparator start.
- dac_data_out  out  DATA_WIDTH  trial code to the decoder data_in.
- result_out  out  DATA_WIDTH  last completed conversion.
- busy_out  out  1  high in any state except IDLE.
- conv_done_out  out  1  single-cycle completion pulse.
- timeout_err_out  out  1  sticky; set on any comparator timeout, cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - State goes to IDLE.
  - Every output is 0: dac_data_out=0, result_out=0, timeout_err_out=0.
  - Bit index and counters are cleared.
- States: IDLE, SAMPLE, TRIAL, WAIT_COMP, DONE.
- IDLE:
  - dac_data_out=0.
  - start=1 moves to SAMPLE; timeout_err_out is cleared on the same edge.
- SAMPLE:
  - sample_out=1 for exactly SAMPLE_CYCLES cycles; dac_data_out=0.
  - Then moves to TRIAL with bit index = DATA_WIDTH-1.
- TRIAL (1 cycle):
  - Sets bit[index] of the working register to 1; dac_data_out shows the working register on the next edge.
  - Asserts comp_trigger_out for this cycle only.
  - Moves to WAIT_COMP; the timeout counter is loaded with 0.
- WAIT_COMP:
  - comp_valid=1: bit[index] takes the value of comp_result.
  - No comp_valid after COMP_TIMEOUT cycles in this state: bit[index] is cleared and timeout_err_out is set.
  - After either resolution: if index=0, go to DONE; else decrement index and go to TRIAL.
- DONE (1 cycle):
  - result_out loads the working register.
  - conv_done_out=1.
  - Next state is IDLE.
- dac_data_out reflects the working register in TRIAL, WAIT_COMP and DONE. The first trial code is 0x800, and codes are monotone per bit decision.
- Latency, comp_valid in the first WAIT_COMP cycle: conv_done_out is high in the cycle following edge SAMPLE_CYCLES + 2*DATA_WIDTH, counted from the edge that samples start (28 edges at defaults).
- Boundaries:
  - start while busy is ignored; no restart and no queueing.
  - comp_valid outside WAIT_COMP is ignored.
  - comp_valid on the same cycle the timeout expires: comp_valid wins and no error is flagged.
  - start in the DONE cycle is ignored.
  - result_out holds its value until the next DONE; it is never partially updated.
  - Reset mid-conversion discards the working register and zeroes result_out.

Decomposition:
- Shared package adc_pkg holds:
  - State encoding enum (IDLE=0, SAMPLE=1, TRIAL=2, WAIT_COMP=3, DONE=4).
  - ADC_DATA_WIDTH=12 constant, used by both the controller and the decoder.
- No sub-module is needed. The sample and timeout counters stay inline, so the block is one FSM plus the working register, roughly 150–200 lines.

Test Plan:
- Ideal comparator model, Vin code 0xA5C, comp_valid one cycle after each trigger:
  - Trial sequence starts 0x800, 0xC00, 0xA00, 0xB00.
  - result_out=0xA5C.
  - conv_done_out pulses exactly 28 edges after start.
- comp_result always 1 -> result_out=0xFFF. Always 0 -> 0x000, and dac_data_out returns to 0x000 in IDLE.
- comp_valid withheld for bit 5 only, Vin code 0xFFF:
  - timeout_err_out=1 after 15 wait cycles.
  - result_out=0xFDF.
  - The next start clears timeout_err_out.
- start pulsed again during WAIT_COMP of bit 7 -> ignored; exactly one conv_done_out, and result is unchanged versus the undisturbed run.
- rst_n low during TRIAL of bit 3:
  - All outputs are 0 immediately, asynchronously.
  - After release, a new start gives a correct conversion of 0x123.
- Spurious comp_valid=1 during SAMPLE and IDLE -> no effect on the working register or result.
